// File: rtl/fifo_drain_if.sv
// Drain-side bundle: FIFO read port, writer push monitor and downstream valid/ready stream.
interface fifo_drain_if #(parameter int DATA_W = 8);
  logic              FIFO_clr;
  logic              push_mon;
  logic              pop;
  logic [DATA_W-1:0] fifo_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              ovf;

  modport master (
    input  FIFO_clr, push_mon, fifo_data, m_ready,
    output pop, m_data, m_valid, ovf
  );
  modport slave (
    output FIFO_clr, push_mon, fifo_data, m_ready,
    input  pop, m_data, m_valid, ovf
  );
endinterface

// File: rtl/fifo_drain.sv
// FIFO read-side drain: shadows occupancy from the writer's push strobe, pops into a 2-entry skid buffer.
module fifo_drain #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic clk,
  input  logic FIFO_reset,
  fifo_drain_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, STALL = 2'd2} st_t;

  st_t               st, st_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [1:0]        bcnt, bcnt_nxt;
  logic              inflight;
  logic              mv_q, ovf_q;
  logic [DATA_W-1:0] buf0, buf1;
  logic              accept, pop_w, push_ok;
  logic [2:0]        occ;

  assign accept  = mv_q && bus.m_ready;
  assign occ     = {1'b0, bcnt} + {2'b00, inflight};
  // occ - accept < 2, rearranged so nothing underflows
  assign pop_w   = (cnt != '0) && !bus.FIFO_clr && (occ < 3'd2 + {2'b00, accept});
  assign push_ok = bus.push_mon && ((cnt != FULL) || pop_w);

  always_comb begin
    cnt_nxt = cnt;
    if (push_ok && !pop_w)      cnt_nxt = cnt + 1'b1;
    else if (pop_w && !push_ok) cnt_nxt = cnt - 1'b1;
    bcnt_nxt = bcnt;
    case ({inflight, accept})
      2'b10:   bcnt_nxt = bcnt + 2'd1;
      2'b01:   bcnt_nxt = bcnt - 2'd1;
      default: bcnt_nxt = bcnt;
    endcase
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:   if (bus.push_mon) st_nxt = ACTIVE;
      ACTIVE: begin
        if ((cnt != '0) && (occ == 3'd2) && !accept)
          st_nxt = STALL;
        else if ((cnt_nxt == '0) && (bcnt_nxt == 2'd0) && !pop_w)
          st_nxt = IDLE;
      end
      STALL:  if (accept) st_nxt = ACTIVE;
      default: st_nxt = IDLE;
    endcase
    if (bus.FIFO_clr) st_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge FIFO_reset) begin
    if (FIFO_reset) begin
      st <= IDLE; cnt <= '0; bcnt <= 2'd0; inflight <= 1'b0;
      mv_q <= 1'b0; ovf_q <= 1'b0; buf0 <= '0; buf1 <= '0;
    end else if (bus.FIFO_clr) begin
      st <= IDLE; cnt <= '0; bcnt <= 2'd0; inflight <= 1'b0;
      mv_q <= 1'b0; ovf_q <= 1'b0; buf0 <= '0; buf1 <= '0;
    end else begin
      st       <= st_nxt;
      cnt      <= cnt_nxt;
      bcnt     <= bcnt_nxt;
      inflight <= pop_w;
      mv_q     <= (bcnt_nxt != 2'd0);
      if (bus.push_mon && (cnt == FULL) && !pop_w) ovf_q <= 1'b1;
      // buf0 is always the head; a capture lands behind whatever survives the accept
      if (inflight && accept) begin
        if (bcnt == 2'd2) begin buf0 <= buf1; buf1 <= bus.fifo_data; end
        else buf0 <= bus.fifo_data;
      end else if (accept) begin
        buf0 <= buf1;
      end else if (inflight) begin
        if (bcnt == 2'd0) buf0 <= bus.fifo_data;
        else              buf1 <= bus.fifo_data;
      end
    end
  end

  assign bus.pop     = pop_w;
  assign bus.m_data  = buf0;
  assign bus.m_valid = mv_q;
  assign bus.ovf     = ovf_q;
endmodule
